register_file_sb: RTL

Parametrised multi-read-port register file with asynchronous clear, a hardwired zero register and a per-register pending scoreboard. It replaces the fixed two-read-port file in the pipelined core's decode stage. Each read port returns the operand value and a "pending" flag. The decode stage uses the flag to stall on read-after-write hazards until writeback clears it.

---
 rtl/register_file_sb_if.sv | 28 ++
 rtl/register_file_sb.sv | 76 +++++++
 2 files changed

// File: rtl/register_file_sb_if.sv
// Operand-read, writeback and issue signals of the scoreboarded register file.
// The decode stage is the master; the register file is the slave.
interface register_file_sb_if #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NRP   = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NRP*AW-1:0]    ra;
  logic [NRP*WIDTH-1:0] rd;
  logic [NRP-1:0]       pend;
  logic                 we3;
  logic [AW-1:0]        a3;
  logic [WIDTH-1:0]     wd3;
  logic                 iss;
  logic [AW-1:0]        iss_a;

  modport master (
    output ra, we3, a3, wd3, iss, iss_a,
    input  rd, pend
  );

  modport slave (
    input  ra, we3, a3, wd3, iss, iss_a,
    output rd, pend
  );
endinterface

// File: rtl/register_file_sb.sv
// Multi-read-port register file with hardwired r0 and a per-register pending scoreboard.
// Optional macro RF_BYPASS_EN: same-cycle write-through forwarding on the read ports.
module register_file_sb #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NRP   = 2
) (
  input logic               clk,
  input logic               rst_n,
  register_file_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend_q;

  logic wr_en_c;
  logic iss_en_c;

  // r0 is never a write or issue target
  assign wr_en_c  = bus.we3 && (bus.a3 != '0);
  assign iss_en_c = bus.iss && (bus.iss_a != '0);

  // Storage and scoreboard; issue is evaluated last so a same-edge issue keeps the bit set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
      pend_q <= '0;
    end else begin
      if (wr_en_c) begin
        mem[bus.a3]    <= bus.wd3;
        pend_q[bus.a3] <= 1'b0;
      end
      if (iss_en_c) begin
        pend_q[bus.iss_a] <= 1'b1;
      end
    end
  end

  logic [NRP-1:0][WIDTH-1:0] rd_c;
  logic [NRP-1:0]            pend_c;

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0] addr_c;

    assign addr_c = bus.ra[p*AW +: AW];

    always_comb begin
      rd_c[p]   = mem[addr_c];
      pend_c[p] = pend_q[addr_c];
      if (addr_c == '0) begin
        rd_c[p]   = '0;
        pend_c[p] = 1'b0;
      end
`ifdef RF_BYPASS_EN
      // Forward writeback data; a colliding issue keeps the stored pending bit visible
      else if (rst_n && wr_en_c && (addr_c == bus.a3)) begin
        rd_c[p] = bus.wd3;
        if (!(iss_en_c && (bus.iss_a == bus.a3))) begin
          pend_c[p] = 1'b0;
        end
      end
`else
      else begin
        rd_c[p]   = mem[addr_c];
        pend_c[p] = pend_q[addr_c];
      end
`endif
    end
  end

  assign bus.rd   = rd_c;
  assign bus.pend = pend_c;
endmodule
